// File: rtl/rv_mem_seq.sv
// rv_mem_seq: memory access sequencer between the multicycle RISC-V
// control/datapath and a single-ported, variable-latency word memory.
// One fetch/load/store is accepted at a time in IDLE. The memory request is
// held stable until mem_ack arrives or the wait budget runs out.
//
// Ports
//   clk, rst           clock, synchronous active-low reset
//   req/we/addr/wdata  access request from control (sampled in IDLE only)
//   busy               high whenever the sequencer is not IDLE
//   done / fault       one-cycle completion / abort pulses
//   rdata              last word read; held until the next read completes
//   fault_code         00 none, 01 misaligned, 10 timeout
//   mem_*              memory-side request/response handshake
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for req; aligned req latches the access, else FAULT
// ACCESS | mem_req held; waits for mem_ack or wait-budget expiry
// DONE   | one-cycle done pulse, then IDLE
// FAULT  | one-cycle fault pulse (misaligned or timeout), then IDLE

module rv_mem_seq #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);
   localparam logic [1:0] CODE_NONE = 2'b00;
   localparam logic [1:0] CODE_MISALIGN = 2'b01;
   localparam logic [1:0] CODE_TIMEOUT = 2'b10;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        mem_we_q, mem_we_d;
   logic [1:0]  fault_code_q, fault_code_d;

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      rdata_d      = rdata_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = mem_we_q;
      fault_code_d = fault_code_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (addr[1:0] != 2'b00) begin
                  fault_code_d = CODE_MISALIGN;
                  state_d      = S_FAULT;
               end else begin
                  mem_addr_d   = addr;
                  mem_wdata_d  = wdata;
                  mem_we_d     = we;
                  wait_cnt_d   = 8'd0;
                  fault_code_d = CODE_NONE;
                  state_d      = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            // An ack in the last budget cycle still completes the access.
            if (mem_ack) begin
               if (!mem_we_q) begin
                  rdata_d = mem_rdata;
               end
               state_d = S_DONE;
            end else if (wait_cnt_q == WAIT_LAST) begin
               fault_code_d = CODE_TIMEOUT;
               state_d      = S_FAULT;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAULT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wait_cnt_q   <= 8'd0;
         rdata_q      <= 32'd0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_we_q     <= 1'b0;
         fault_code_q <= CODE_NONE;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         rdata_q      <= rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         fault_code_q <= fault_code_d;
      end
   end

   // Handshake outputs decode straight from the state register.
   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign fault      = (state_q == S_FAULT);
   assign mem_req    = (state_q == S_ACCESS);
   assign mem_we     = mem_we_q & (state_q == S_ACCESS);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign rdata      = rdata_q;
   assign fault_code = fault_code_q;

endmodule
